instr_write_sequencer: RTL
==========================

Name: instr_write_sequencer

Overview:
- Upstream feeder for the instruction register.
- Accepts instruction beats (opcode, operand_a, operand_b, optional address) over a valid/ready handshake and buffers them in a small FIFO.
- Issues one register write per cycle on the register's load_en / write_pointer / operand / opcode inputs.
- Generates write addresses incrementally, decrementally or from the beat itself.
- Keeps a written-location mask for the downstream checker and scoreboard.

Parameters:
- FIFO_DEPTH, 4, buffer entries (power of 2, at least 2).
- WR_MODE, 0, address mode: 0 incremental, 1 decremental, 2 explicit (uses in_addr).
- START_ADDR, 0, first write address after reset or flush (address_t range 0..31).

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  FIFO can accept a beat.
- in_opcode  input  opcode_t  beat opcode.
- in_op_a  input  operand_t  beat operand A (signed).
- in_op_b  input  operand_t  beat operand B.
- in_addr  input  address_t  beat address; used only when WR_MODE=2.
- hold  input  1  stall issue; FIFO still accepts beats.
- flush  input  1  discard buffered beats and rewind the address.
- load_en  output  1  register write strobe.
- write_pointer  output  address_t  register write address.
- operand_a  output  operand_t  register operand A.
- operand_b  output  operand_t  register operand B.
- opcode  output  opcode_t  register opcode.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  buffered beat count.
- written_mask  output  32  bit i is set once address i has been written.
- issue_count  output  16  total writes issued since reset or flush; saturates at 16'hFFFF.

Behaviour:
- Reset (synchronous, highest priority) sets:
  - load_en=0, write_pointer=START_ADDR, operand_a=0, operand_b=0, opcode=ZERO;
  - FIFO empty, fifo_count=0, written_mask=0, issue_count=0.
- in_ready = (fifo_count < FIFO_DEPTH) && !flush && !reset; combinational from registered state only.
- Push: a beat is accepted on a posedge where in_valid && in_ready.
  - When full, no push occurs even if a pop happens in the same cycle; in_ready stays 0 for that cycle.
- Pop/issue: on a posedge where the FIFO is non-empty && !hold && !flush, the head is popped into the output registers and load_en is set to 1.
  - Otherwise load_en is set to 0. Data outputs hold their last values.
- Latency: a beat accepted at edge N into an empty FIFO (hold=0) drives load_en=1 after edge N+1. The register captures it at edge N+2.
- Throughput: one issue per cycle; with back-to-back input, steady state is 1 beat per cycle.
- Simultaneous push and pop when not full: both occur and fifo_count is unchanged.
- Address generation (computed at issue):
  - Mode 0: first issue uses START_ADDR, then +1 per issue; 31 wraps to 0.
  - Mode 1: first issue uses START_ADDR, then -1 per issue; 0 wraps to 31.
  - Mode 2: write_pointer = the beat's captured in_addr.
- written_mask: at each issue, bit[write_pointer] is set. Bits are never cleared except by reset or flush.
- issue_count: increments at each issue and saturates.
- flush (synchronous, below reset in priority):
  - FIFO emptied, next address rewound to START_ADDR, written_mask=0, issue_count=0;
  - load_en=0 after the edge; any push attempted in the same cycle is dropped.
- hold asserted mid-stream: load_en drops after the next edge; the FIFO keeps filling until full.
- Reset mid-stream: all buffered beats are lost; no write is issued in the cycle after reset.
- Arithmetic: address math is modulo 32 on address_t. Operands pass through unmodified (no sign change, no truncation).

Decomposition:
- instr_register_pkg gains:
  - wr_mode_t enum {WR_INC, WR_DEC, WR_EXPLICIT};
  - beat_t struct {opcode_t opc; operand_t op_a; operand_t op_b; address_t addr}.
- Existing opcode_t, operand_t, address_t are reused from the package.
- Sub-module instr_beat_fifo: synchronous FIFO of beat_t.
  - Parameter DEPTH.
  - Ports push, pop, flush, din, dout, count, full, empty.
  - Same clk/reset scheme.
- The sequencer top holds the address counter, issue control, mask and counters.

Test Plan:
1. Reset then 5 beats back-to-back, WR_MODE=0, START_ADDR=0 -> load_en high 5 consecutive cycles, write_pointer 0,1,2,3,4, written_mask=32'h1F, issue_count=5.
2. WR_MODE=1, START_ADDR=1, 3 beats -> write_pointer 1,0,31 (wrap); written_mask=32'h8000_0003.
3. hold=1, then 6 beats offered, FIFO_DEPTH=4 -> 4 accepted, in_ready=0, fifo_count=4, load_en=0. Release hold -> 4 issues, then the 2 remaining beats are accepted and issued.
4. WR_MODE=2, beats with in_addr 7,7,20 and op_a -5,3,15 -> writes to 7,7,20 in order; operand_a=-5 passes unchanged; written_mask=32'h0010_0080.
5. flush asserted with 3 beats buffered and in_valid=1 -> next cycle fifo_count=0, load_en=0, written_mask=0, issue_count=0. The next beat is written to START_ADDR.
6. reset asserted for 1 cycle during continuous issue -> after the edge all outputs are at reset values and load_en=0. The following beat is issued at START_ADDR with latency 1.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its upstream write sequencer.
// Holds the operand/opcode/address types, the address-mode enum and the beat record.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef enum logic [1:0] {
        WR_INC      = 2'd0,
        WR_DEC      = 2'd1,
        WR_EXPLICIT = 2'd2
    } wr_mode_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        address_t addr;
    } beat_t;

    localparam logic [15:0] ISSUE_MAX = 16'hFFFF;

    // 5-bit arithmetic gives the modulo-32 wrap in both directions.
    function automatic address_t step_addr(input address_t a, input wr_mode_t m);
        step_addr = (m == WR_DEC) ? a - 5'd1 : a + 5'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        sat_inc16 = (v == ISSUE_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/instr_write_sequencer_fifo.sv
// Synchronous FIFO of instruction beats; flush and reset both empty it in one edge.
// A push against a full FIFO is ignored even when a pop happens in the same cycle.
module instr_beat_fifo
    import instr_register_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  beat_t                  din,
    output beat_t                  dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    beat_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push && !reset && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instr_write_sequencer.sv
// Feeds the instruction register: buffers beats, issues one write per cycle,
// generates the write address and tracks which locations have been written.
module instr_write_sequencer
    import instr_register_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WR_MODE    = 0,
    parameter int START_ADDR = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  opcode_t                     in_opcode,
    input  operand_t                    in_op_a,
    input  operand_t                    in_op_b,
    input  address_t                    in_addr,
    input  logic                        hold,
    input  logic                        flush,
    output logic                        load_en,
    output address_t                    write_pointer,
    output operand_t                    operand_a,
    output operand_t                    operand_b,
    output opcode_t                     opcode,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [31:0]                 written_mask,
    output logic [15:0]                 issue_count
);

    localparam wr_mode_t MODE  = wr_mode_t'(WR_MODE);
    localparam address_t START = address_t'(START_ADDR);

    beat_t    in_beat;
    beat_t    head;
    logic     full;
    logic     empty;
    logic     push;
    logic     pop;
    address_t next_addr;
    address_t issue_addr;

    assign in_beat    = '{opc: in_opcode, op_a: in_op_a, op_b: in_op_b, addr: in_addr};
    assign in_ready   = !full && !flush && !reset;
    assign push       = in_valid && in_ready;
    assign pop        = !empty && !hold && !flush && !reset;
    assign issue_addr = (MODE == WR_EXPLICIT) ? head.addr : next_addr;

    instr_beat_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (in_beat),
        .dout  (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    // Issue stage: the popped head lands in the register-facing outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_en       <= 1'b0;
            write_pointer <= START;
            operand_a     <= '0;
            operand_b     <= '0;
            opcode        <= ZERO;
            next_addr     <= START;
            written_mask  <= '0;
            issue_count   <= '0;
        end else if (flush) begin
            load_en      <= 1'b0;
            next_addr    <= START;
            written_mask <= '0;
            issue_count  <= '0;
        end else if (pop) begin
            load_en       <= 1'b1;
            write_pointer <= issue_addr;
            operand_a     <= head.op_a;
            operand_b     <= head.op_b;
            opcode        <= head.opc;
            next_addr     <= step_addr(next_addr, MODE);
            written_mask  <= written_mask | (32'd1 << issue_addr);
            issue_count   <= sat_inc16(issue_count);
        end else begin
            load_en <= 1'b0;
        end
    end

endmodule
